frame_capture: RTL and testbench

- Write-side controller for the scope frame RAM: samples adc_db on each sample strobe and writes it into a circular buffer.
- Detects a level/slope trigger and stops after a full frame has been captured around the trigger point.
- Hands the finished frame to the display/readout side with a ready/ack handshake, including the frame start address.
- Sits between the ADC inputs and the frame RAM write port; the readout address generator consumes frame_start.

---
 rtl/frame_capture.sv | 145 ++++++++++++++
 tb/tb_frame_capture.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture.sv
// frame_capture: write side of the scope frame RAM; circular pre/post-trigger capture with ready/ack hand-off.
// Define FRAME_CAPTURE_AUTO_TRIG_EN to force a trigger after AUTO_TIMEOUT armed samples.
module frame_capture #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 8,
    parameter int FRAME_LEN    = 400,
    parameter int PRETRIG      = 100,
    parameter int AUTO_TIMEOUT = 1000
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] adc_db,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic              continuous,
    input  logic              arm,
    input  logic              frame_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_ready,
    output logic [ADDR_W-1:0] frame_start,
    output logic              busy
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
    localparam logic [ADDR_W-1:0] WRAP_OFS  = ADDR_W'(FRAME_LEN - PRETRIG);
    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRETRIG - 1);
    localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(FRAME_LEN - PRETRIG - 1);

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;

    // With no pre-trigger history the capture begins directly in ARMED.
    localparam state_t START_ST = (PRETRIG == 0) ? ARMED : PRE;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] prev;
    logic              trig_hit;
    logic              fire;
    logic              do_write;
    logic [ADDR_W-1:0] ptr_nxt;
    logic [ADDR_W-1:0] trig_start;

    always_comb begin
        trig_hit = 1'b0;
        if (trig_slope) trig_hit = (prev < trig_level) && (adc_db >= trig_level);
        else            trig_hit = (prev > trig_level) && (adc_db <= trig_level);
    end

    assign do_write   = sample_en && (state == PRE || state == ARMED || state == POST);
    assign ptr_nxt    = (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
    assign trig_start = (ptr >= PRE_OFS) ? ptr - PRE_OFS : ptr + WRAP_OFS;

`ifdef FRAME_CAPTURE_AUTO_TRIG_EN
    localparam int AUTO_W = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TIMEOUT - 1);

    logic [AUTO_W-1:0] auto_cnt;

    assign fire = trig_hit || (auto_cnt == AUTO_LAST);

    // Held at zero outside ARMED, so it is clear on every entry to ARMED.
    always_ff @(posedge clock or posedge rst) begin
        if (rst)                          auto_cnt <= '0;
        else if (state != ARMED)          auto_cnt <= '0;
        else if (sample_en && !fire)      auto_cnt <= auto_cnt + 1'b1;
    end
`else
    assign fire = trig_hit;
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_ready <= 1'b0;
            frame_start <= '0;
            busy        <= 1'b0;
            ptr         <= '0;
            cnt         <= '0;
            prev        <= '0;
        end else begin
            wr_en <= 1'b0;
            if (do_write) begin
                wr_en   <= 1'b1;
                wr_addr <= ptr;
                wr_data <= adc_db;
                prev    <= adc_db;
                ptr     <= ptr_nxt;
            end
            case (state)
                IDLE: if (arm || (continuous && !frame_ready)) begin
                    state <= START_ST;
                    ptr   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
                PRE: if (sample_en) begin
                    if (cnt == PRE_LAST) state <= ARMED;
                    else                 cnt   <= cnt + 1'b1;
                end
                ARMED: if (sample_en && fire) begin
                    frame_start <= trig_start;
                    cnt         <= CNT_W'(1);
                    if (POST_LAST == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        state <= POST;
                    end
                end
                POST: if (sample_en) begin
                    if (cnt == POST_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: if (frame_ready && frame_ack) begin
                    frame_ready <= 1'b0;
                    if (continuous) begin
                        state <= START_ST;
                        ptr   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    frame_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_capture.sv
// Directed + randomized bench for frame_capture; expected frames are derived from the sample list itself.
module tb_frame_capture;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int L      = 16;
    localparam int P      = 4;
    localparam int AT     = 8;

    logic              clock = 1'b0;
    logic              rst = 1'b1;
    logic              sample_en = 1'b0;
    logic [DATA_W-1:0] adc_db = '0;
    logic [DATA_W-1:0] trig_level = 8'h80;
    logic              trig_slope = 1'b1;
    logic              continuous = 1'b0;
    logic              arm = 1'b0;
    logic              frame_ack = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_ready;
    logic [ADDR_W-1:0] frame_start;
    logic              busy;

    frame_capture #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_LEN(L), .PRETRIG(P), .AUTO_TIMEOUT(AT)
    ) dut (
        .clock(clock), .rst(rst), .sample_en(sample_en), .adc_db(adc_db),
        .trig_level(trig_level), .trig_slope(trig_slope), .continuous(continuous),
        .arm(arm), .frame_ack(frame_ack), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_ready(frame_ready), .frame_start(frame_start), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               wr_q[$];
    int                cyc = 0;
    int                last_wr_cyc = -1;
    int                rdy_rise_cyc = -1;
    logic              rdy_d = 1'b0;
    logic [DATA_W-1:0] smp [0:127];
    int                checks = 0;
    int                errors = 0;

    // Observe the write port and the ready edge away from the active clock edge.
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (wr_en === 1'b1) begin
            wr_q.push_back('{addr: wr_addr, data: wr_data});
            last_wr_cyc = cyc;
        end
        if (frame_ready === 1'b1 && rdy_d !== 1'b1) rdy_rise_cyc = cyc;
        rdy_d = frame_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Index of the trigger sample within a capture, or -1 if the frame never triggers.
    function automatic int find_trig(input int n);
        logic [DATA_W-1:0] a, b;
        for (int i = P; i < n; i++) begin
            a = smp[i-1];
            b = smp[i];
`ifdef FRAME_CAPTURE_AUTO_TRIG_EN
            if (i - P + 1 == AT) return i;
`endif
            if (trig_slope  && int'(a) < int'(trig_level) && int'(b) >= int'(trig_level)) return i;
            if (!trig_slope && int'(a) > int'(trig_level) && int'(b) <= int'(trig_level)) return i;
        end
        return -1;
    endfunction

    task automatic drive_samples(input int n, input int arm_at, input int ack_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            sample_en = 1'b1; adc_db = smp[i]; arm = 1'b0; frame_ack = 1'b0;
            @(negedge clock);
            sample_en = 1'b0; arm = (i == arm_at); frame_ack = (i == ack_at);
        end
        @(negedge clock);
        arm = 1'b0; frame_ack = 1'b0;
    endtask

    task automatic pulse_arm();
        @(negedge clock); arm = 1'b1;
        @(negedge clock); arm = 1'b0;
    endtask

    task automatic capture(input string tag, input int n, input int arm_at, input int ack_at);
        int k, nw;
        wr_q.delete();
        rdy_rise_cyc = -1;
        drive_samples(n, arm_at, ack_at);
        repeat (2) @(negedge clock);
        k  = find_trig(n);
        nw = (k < 0) ? n : ((n < k + L - P) ? n : k + L - P);
        chk({tag, " nwr"}, wr_q.size(), nw);
        for (int i = 0; i < wr_q.size() && i < nw; i++) begin
            chk($sformatf("%s addr%0d", tag, i), 32'(wr_q[i].addr), i % L);
            chk($sformatf("%s data%0d", tag, i), 32'(wr_q[i].data), 32'(smp[i]));
        end
        if (k >= 0 && n >= k + L - P) begin
            chk({tag, " ready"}, 32'(frame_ready), 1);
            chk({tag, " start"}, 32'(frame_start), ((k - P) % L + L) % L);
            chk({tag, " busy"}, 32'(busy), 0);
            chk({tag, " rdy_lat"}, rdy_rise_cyc, last_wr_cyc + 1);
        end else begin
            chk({tag, " ready"}, 32'(frame_ready), 0);
            chk({tag, " busy"}, 32'(busy), 1);
        end
    endtask

    task automatic do_ack(input string tag, input logic cont);
        @(negedge clock); frame_ack = 1'b1;
        @(negedge clock); frame_ack = 1'b0;
        chk({tag, " ack_ready"}, 32'(frame_ready), 0);
        chk({tag, " ack_busy"}, 32'(busy), 32'(cont));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " wr_en"}, 32'(wr_en), 0);
        chk({tag, " wr_addr"}, 32'(wr_addr), 0);
        chk({tag, " wr_data"}, 32'(wr_data), 0);
        chk({tag, " ready"}, 32'(frame_ready), 0);
        chk({tag, " start"}, 32'(frame_start), 0);
        chk({tag, " busy"}, 32'(busy), 0);
    endtask

    task automatic idle_quiet(input string tag);
        for (int i = 0; i < 8; i++) smp[i] = 8'($urandom);
        wr_q.delete();
        drive_samples(8, -1, -1);
        chk({tag, " idle_nwr"}, wr_q.size(), 0);
        chk({tag, " idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        chk_zero("reset");
        rst = 1'b0;
        idle_quiet("reset");

        // Rising trigger on a ramp, single shot
        trig_slope = 1'b1; trig_level = 8'h80; continuous = 1'b0;
        for (int i = 0; i < 24; i++) smp[i] = 8'(i * 16);
        pulse_arm();
        capture("rise", 24, -1, -1);
        chk("rise start_const", 32'(frame_start), 4);
        chk("rise trig_addr", 32'(wr_q[8].addr), 8);
        do_ack("rise", 1'b0);
        idle_quiet("rise");

        // Stray arm in ARMED and ack in POST must not disturb the capture
        pulse_arm();
        capture("ignore", 24, 5, 10);
        do_ack("ignore", 1'b0);

        // Falling trigger after the pointer has wrapped
        trig_slope = 1'b0; trig_level = 8'h40;
        for (int i = 0; i < 20; i++) smp[i] = 8'hFF;
        smp[20] = 8'h30;
        for (int i = 21; i < 36; i++) smp[i] = 8'($urandom);
        pulse_arm();
        capture("fall", 36, -1, -1);
`ifndef FRAME_CAPTURE_AUTO_TRIG_EN
        chk("fall start_const", 32'(frame_start), 0);
        chk("fall trig_addr", 32'(wr_q[20].addr), 4);
`endif
        do_ack("fall", 1'b0);

        // Continuous re-arm with randomized data, slope and level
        continuous = 1'b1;
        for (int r = 0; r < 4; r++) begin
            trig_slope = 1'($urandom);
            trig_level = 8'($urandom_range(8'h20, 8'hE0));
            for (int i = 0; i < 60; i++) smp[i] = 8'($urandom);
            smp[30] = trig_slope ? 8'h00 : 8'hFF;
            smp[31] = trig_slope ? 8'hFF : 8'h00;
            capture($sformatf("cont%0d", r), 60, -1, -1);
            if (r == 3) continuous = 1'b0;
            do_ack($sformatf("cont%0d", r), r != 3);
        end

        // Forced trigger on a flat input
        trig_slope = 1'b1; trig_level = 8'h80;
        for (int i = 0; i < 100; i++) smp[i] = 8'h00;
        pulse_arm();
`ifdef FRAME_CAPTURE_AUTO_TRIG_EN
        capture("auto", 30, -1, -1);
        chk("auto start_const", 32'(frame_start), 7);
`else
        capture("auto", 100, -1, -1);
`endif
        @(negedge clock); rst = 1'b1;
        @(negedge clock); rst = 1'b0;
        chk_zero("auto_rst");

        // Reset mid-POST abandons the frame
        for (int i = 0; i < 24; i++) smp[i] = 8'(i * 16);
        pulse_arm();
        capture("midpost", 11, -1, -1);
        @(negedge clock); rst = 1'b1;
        @(posedge clock); #1;
        chk_zero("midpost_rst");
        @(negedge clock); rst = 1'b0;
        idle_quiet("midpost");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
